cplx_mag2_accum: RTL and testbench
==================================

# cplx_mag2_accum

Streaming power estimator placed directly downstream of the complex conjugate stage. It computes |x|² = I² + Q² for each valid complex sample and accumulates it over blocks of 2^ACCUM_LOG2 samples, or shorter blocks delimited by sof/eof. At the end of each block it emits one scaled, saturated power value with sof/eof tags. The pipeline is three cycles deep and accepts one sample per clock with no backpressure.

## Interface
- DATA_SIZE, 16: width of signed input I and Q.
- ACCUM_LOG2, 8: nominal block length N = 2^ACCUM_LOG2 samples (1..16).
- SHIFT, 0: right shift applied to the accumulator before output (0..2*DATA_SIZE+ACCUM_LOG2).
- DATA_OUT_SIZE, 32: width of the unsigned output power word.
- data_clk_i  in  1  the single clock, rising edge.
- data_rst_i  in  1  reset, asynchronous, active-low.
- data_i_i  in  DATA_SIZE  signed I sample.
- data_q_i  in  DATA_SIZE  signed Q sample.
- data_en_i  in  1  sample valid; one sample accepted per clock when high.
- data_sof_i  in  1  first sample of a frame; meaningful only with data_en_i.
- data_eof_i  in  1  last sample of a frame; meaningful only with data_en_i.
- data_o  out  DATA_OUT_SIZE  unsigned block power, saturated.
- data_en_o  out  1  one-cycle strobe, data_o valid.
- data_sof_o  out  1  block was opened by data_sof_i; valid with data_en_o.
- data_eof_o  out  1  block was closed by data_eof_i; valid with data_en_o.
- data_ovf_o  out  1  data_o saturated; valid with data_en_o.

## Operation
- Stage 1: register ii = I*I and qq = Q*Q. Each is 2*DATA_SIZE bits unsigned; the largest value is (-2^(DATA_SIZE-1))² = 2^(2*DATA_SIZE-2).
- Stage 2: register p = ii + qq. p is 2*DATA_SIZE+1 bits and does not overflow.
- Stage 3: acc = (first ? 0 : acc) + p. acc is 2*DATA_SIZE+1+ACCUM_LOG2 bits and never wraps for blocks of N samples or fewer.
- The sof, eof and en flags travel alongside the data through stages 1 and 2.
- Sample counter cnt, ACCUM_LOG2 bits, advances at stage 3. Each stage-3 sample is one of:
  - Opening: sof set, or first sample after reset, or first sample after a block closed. It sets first=1, cnt=0, and latches blk_sof = sof.
  - Closing: cnt == N-1, or eof set. It triggers output and arms "next is opening".
- sof on a sample inside an open block discards the partial accumulation with no output. That sample starts a fresh block.
- sof and eof on the same sample give a one-sample block: data_o = p>>SHIFT, with data_sof_o=1 and data_eof_o=1.
- eof on the N-th sample gives a single output with data_eof_o=1.
- N=1 (ACCUM_LOG2=0 is not allowed; minimum is 1): N=2 closes every second sample.
- Output on close:
  - r = (acc_new) >> SHIFT.
  - If r > 2^DATA_OUT_SIZE-1, then data_o = all ones and data_ovf_o = 1. Otherwise data_o = r[DATA_OUT_SIZE-1:0] and data_ovf_o = 0.
  - data_sof_o = blk_sof; data_eof_o = eof of the closing sample.
- data_o, data_sof_o, data_eof_o and data_ovf_o hold their values between strobes.
- Cycles with data_en_i low are ignored: no count, no accumulation, no output. Gaps inside a block are allowed.

## Timing
- Reset (data_rst_i low, asynchronous) clears:
  - all pipeline registers, acc, cnt and blk_sof;
  - data_o=0, data_en_o=0, data_sof_o=0, data_eof_o=0, data_ovf_o=0;
  - the next accepted sample becomes opening.
- Reset deassertion is synchronous to data_clk_i via an external synchronizer; the block itself does not resynchronize.
- Latency: if the closing sample is sampled at rising edge t, data_en_o is high for exactly the cycle after edge t+3. data_o is updated at that same edge t+3.
- Throughput: one sample per clock, back-to-back blocks with no dead cycle. The opening sample of block k+1 may directly follow the closing sample of block k.
- Reset mid-block drops the partial block and any in-flight pipeline contents. No output is produced for them.

## Test plan
- Default parameters, 256 consecutive samples I=100, Q=-200, sof on sample 0 -> one strobe 3 cycles after sample 255. data_o = 256*50000 = 12 800 000, sof_o=1, eof_o=0, ovf_o=0.
- 10 samples I=3, Q=4 with sof on the first and eof on the last, en toggled every other cycle -> one strobe with data_o=250, sof_o=1, eof_o=1. No other strobes.
- Single sample I=Q=-32768 with sof and eof -> data_o=2^31, sof_o=eof_o=1, latency 3 cycles.
- DATA_OUT_SIZE=16, SHIFT=0, 256 samples I=Q=1000 -> data_o=65535, ovf_o=1. With SHIFT=16 the same stimulus gives data_o=7812, ovf_o=0.
- sof at sample 0, another sof at sample 50, then 255 more samples of I=1, Q=0 -> only one strobe, 3 cycles after sample 305, data_o=256.
- Reset asserted 100 samples into a block, then released and 256 samples of I=2, Q=0 fed -> all outputs 0 while in reset. Exactly one strobe follows with data_o=1024.

Source files
------------

// File: rtl/cplx_mag2_accum.sv
// Streaming |x|^2 power estimator: squares I/Q, sums them, accumulates over
// blocks of 2^ACCUM_LOG2 samples (or sof/eof-delimited blocks) and emits one
// scaled, saturated power word per block, three clocks after the closing sample.
module cplx_mag2_accum #(
    parameter int unsigned DATA_SIZE     = 16,
    parameter int unsigned ACCUM_LOG2    = 8,
    parameter int unsigned SHIFT         = 0,
    parameter int unsigned DATA_OUT_SIZE = 32
) (
    input  logic                     data_clk_i,
    input  logic                     data_rst_i,
    input  logic [DATA_SIZE-1:0]     data_i_i,
    input  logic [DATA_SIZE-1:0]     data_q_i,
    input  logic                     data_en_i,
    input  logic                     data_sof_i,
    input  logic                     data_eof_i,
    output logic [DATA_OUT_SIZE-1:0] data_o,
    output logic                     data_en_o,
    output logic                     data_sof_o,
    output logic                     data_eof_o,
    output logic                     data_ovf_o
);

    localparam int unsigned MW = 2 * DATA_SIZE;
    localparam int unsigned PW = MW + 1;
    localparam int unsigned AW = PW + ACCUM_LOG2;
    localparam int unsigned CW = ACCUM_LOG2;
    localparam int unsigned XW = (AW > DATA_OUT_SIZE) ? AW : DATA_OUT_SIZE;
    localparam logic [CW-1:0] CNT_LAST = {CW{1'b1}};

    typedef enum logic {
        ST_OPEN  = 1'b0,
        ST_ACCUM = 1'b1
    } state_e;

    // ---------------- stage 1: squares ----------------
    logic signed [MW-1:0] i_ext_c;
    logic signed [MW-1:0] q_ext_c;
    logic [MW-1:0]        ii_d, qq_d;
    logic [MW-1:0]        ii_q, qq_q;
    logic                 en1_q, sof1_q, eof1_q;

    assign i_ext_c = MW'($signed(data_i_i));
    assign q_ext_c = MW'($signed(data_q_i));
    assign ii_d    = $unsigned(i_ext_c * i_ext_c);
    assign qq_d    = $unsigned(q_ext_c * q_ext_c);

    // Stage 1 register: squares plus qualified frame flags
    always_ff @(posedge data_clk_i or negedge data_rst_i) begin
        if (!data_rst_i) begin
            ii_q   <= '0;
            qq_q   <= '0;
            en1_q  <= 1'b0;
            sof1_q <= 1'b0;
            eof1_q <= 1'b0;
        end else begin
            ii_q   <= ii_d;
            qq_q   <= qq_d;
            en1_q  <= data_en_i;
            sof1_q <= data_sof_i & data_en_i;
            eof1_q <= data_eof_i & data_en_i;
        end
    end

    // ---------------- stage 2: instantaneous power ----------------
    logic [PW-1:0] p_d, p_q;
    logic          en2_q, sof2_q, eof2_q;

    assign p_d = PW'(ii_q) + PW'(qq_q);

    // Stage 2 register: p = I^2 + Q^2 and flags
    always_ff @(posedge data_clk_i or negedge data_rst_i) begin
        if (!data_rst_i) begin
            p_q    <= '0;
            en2_q  <= 1'b0;
            sof2_q <= 1'b0;
            eof2_q <= 1'b0;
        end else begin
            p_q    <= p_d;
            en2_q  <= en1_q;
            sof2_q <= sof1_q;
            eof2_q <= eof1_q;
        end
    end

    // ---------------- stage 3: block accumulation ----------------
    state_e        state_q, state_d;
    logic          opening_c;
    logic          close_c;
    logic [CW-1:0] idx_c;

    logic [AW-1:0] acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          blk_sof_q, blk_sof_d;
    logic          close_q, close_sof_q, close_eof_q;

    // Block state register: ST_OPEN means the next valid sample opens a block
    always_ff @(posedge data_clk_i or negedge data_rst_i) begin
        if (!data_rst_i) begin
            state_q <= ST_OPEN;
        end else begin
            state_q <= state_d;
        end
    end

    // Classify the stage-3 sample as opening/closing and pick next block state
    always_comb begin
        state_d   = state_q;
        opening_c = 1'b0;
        close_c   = 1'b0;
        idx_c     = cnt_q;
        if (en2_q) begin
            opening_c = sof2_q | (state_q == ST_OPEN);
            idx_c     = opening_c ? '0 : cnt_q + CW'(1);
            close_c   = (idx_c == CNT_LAST) | eof2_q;
            state_d   = close_c ? ST_OPEN : ST_ACCUM;
        end
    end

    // Accumulator, sample index and block-sof next values
    always_comb begin
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        blk_sof_d = blk_sof_q;
        if (en2_q) begin
            acc_d = (opening_c ? '0 : acc_q) + AW'(p_q);
            cnt_d = idx_c;
        end
        if (opening_c) begin
            blk_sof_d = sof2_q;
        end
    end

    // Stage 3 register: accumulator state and the close event for the output stage
    always_ff @(posedge data_clk_i or negedge data_rst_i) begin
        if (!data_rst_i) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            blk_sof_q   <= 1'b0;
            close_q     <= 1'b0;
            close_sof_q <= 1'b0;
            close_eof_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            blk_sof_q   <= blk_sof_d;
            close_q     <= close_c;
            close_sof_q <= blk_sof_d;
            close_eof_q <= eof2_q;
        end
    end

    // ---------------- output stage: scale and saturate ----------------
    logic [XW-1:0]            r_c;
    logic                     sat_c;
    logic [DATA_OUT_SIZE-1:0] dout_d, dout_q;
    logic                     en_o_d, sof_o_d, eof_o_d, ovf_o_d;
    logic                     en_o_q, sof_o_q, eof_o_q, ovf_o_q;

    assign r_c   = XW'(acc_q) >> SHIFT;
    assign sat_c = |(r_c >> DATA_OUT_SIZE);

    // Output next values: update on a close, otherwise hold with strobe low
    always_comb begin
        dout_d  = dout_q;
        sof_o_d = sof_o_q;
        eof_o_d = eof_o_q;
        ovf_o_d = ovf_o_q;
        en_o_d  = close_q;
        if (close_q) begin
            dout_d  = sat_c ? '1 : DATA_OUT_SIZE'(r_c);
            ovf_o_d = sat_c;
            sof_o_d = close_sof_q;
            eof_o_d = close_eof_q;
        end
    end

    // Output registers
    always_ff @(posedge data_clk_i or negedge data_rst_i) begin
        if (!data_rst_i) begin
            dout_q  <= '0;
            en_o_q  <= 1'b0;
            sof_o_q <= 1'b0;
            eof_o_q <= 1'b0;
            ovf_o_q <= 1'b0;
        end else begin
            dout_q  <= dout_d;
            en_o_q  <= en_o_d;
            sof_o_q <= sof_o_d;
            eof_o_q <= eof_o_d;
            ovf_o_q <= ovf_o_d;
        end
    end

    assign data_o     = dout_q;
    assign data_en_o  = en_o_q;
    assign data_sof_o = sof_o_q;
    assign data_eof_o = eof_o_q;
    assign data_ovf_o = ovf_o_q;

endmodule

// File: tb/tb_cplx_mag2_accum.sv
// Bench for cplx_mag2_accum: three instances (default, 16-bit out, 16-bit out
// with SHIFT=16) share one stimulus stream and one block-level power model.
module tb_cplx_mag2_accum;

    localparam int unsigned NDUT = 3;
    localparam int          NBLK = 256;

    logic        clk;
    logic        rst_n;
    logic [15:0] di, dq;
    logic        en_i, sof_i, eof_i;

    logic [31:0] d0;
    logic [15:0] d1, d2;
    logic [2:0]  act_en, act_sof, act_eof, act_ovf;
    logic [31:0] act_d [NDUT];

    int unsigned cfg_dos [NDUT] = '{32, 16, 16};
    int unsigned cfg_sh  [NDUT] = '{0, 0, 16};

    int checks   = 0;
    int failures = 0;

    cplx_mag2_accum #(.DATA_SIZE(16), .ACCUM_LOG2(8), .SHIFT(0), .DATA_OUT_SIZE(32)) u_dut0 (
        .data_clk_i(clk), .data_rst_i(rst_n), .data_i_i(di), .data_q_i(dq),
        .data_en_i(en_i), .data_sof_i(sof_i), .data_eof_i(eof_i),
        .data_o(d0), .data_en_o(act_en[0]), .data_sof_o(act_sof[0]),
        .data_eof_o(act_eof[0]), .data_ovf_o(act_ovf[0]));

    cplx_mag2_accum #(.DATA_SIZE(16), .ACCUM_LOG2(8), .SHIFT(0), .DATA_OUT_SIZE(16)) u_dut1 (
        .data_clk_i(clk), .data_rst_i(rst_n), .data_i_i(di), .data_q_i(dq),
        .data_en_i(en_i), .data_sof_i(sof_i), .data_eof_i(eof_i),
        .data_o(d1), .data_en_o(act_en[1]), .data_sof_o(act_sof[1]),
        .data_eof_o(act_eof[1]), .data_ovf_o(act_ovf[1]));

    cplx_mag2_accum #(.DATA_SIZE(16), .ACCUM_LOG2(8), .SHIFT(16), .DATA_OUT_SIZE(16)) u_dut2 (
        .data_clk_i(clk), .data_rst_i(rst_n), .data_i_i(di), .data_q_i(dq),
        .data_en_i(en_i), .data_sof_i(sof_i), .data_eof_i(eof_i),
        .data_o(d2), .data_en_o(act_en[2]), .data_sof_o(act_sof[2]),
        .data_eof_o(act_eof[2]), .data_ovf_o(act_ovf[2]));

    assign act_d[0] = d0;
    assign act_d[1] = 32'(d1);
    assign act_d[2] = 32'(d2);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- block-level model ----------------
    typedef struct {
        int     due;
        longint sum;
        bit     sof;
        bit     eof;
    } ev_t;

    ev_t    evq[$];
    int     cyc      = 0;
    bit     m_open   = 1'b1;
    longint m_sum    = 0;
    int     m_cnt    = 0;
    bit     m_blksof = 1'b0;

    longint exp_d   [NDUT];
    bit     exp_en  [NDUT];
    bit     exp_sof [NDUT];
    bit     exp_eof [NDUT];
    bit     exp_ovf [NDUT];

    int     strobes [NDUT];
    longint last_d  [NDUT];
    bit     last_sof[NDUT];
    bit     last_eof[NDUT];
    bit     last_ovf[NDUT];

    // Accepted samples at each rising edge; a closed block is due 3 edges later
    always @(posedge clk) begin
        longint p;
        cyc = cyc + 1;
        if (rst_n && en_i) begin
            p = longint'($signed(di)) * longint'($signed(di))
              + longint'($signed(dq)) * longint'($signed(dq));
            if (sof_i || m_open) begin
                m_sum    = p;
                m_cnt    = 0;
                m_blksof = sof_i;
                m_open   = 1'b0;
            end else begin
                m_sum = m_sum + p;
                m_cnt = m_cnt + 1;
            end
            if (m_cnt == NBLK - 1 || eof_i) begin
                evq.push_back('{due: cyc + 3, sum: m_sum, sof: m_blksof, eof: eof_i});
                m_open = 1'b1;
            end
        end
    end

    task automatic chk(input string name, input int k, input longint act, input longint exp);
        checks = checks + 1;
        if (act != exp) begin
            failures = failures + 1;
            $display("FAIL %s dut%0d cyc=%0d got=%0d exp=%0d", name, k, cyc, act, exp);
        end
    endtask

    // Compare every output of every instance on each falling edge
    always @(negedge clk) begin
        ev_t    e;
        longint r, mx;
        bit     hit;
        hit = 1'b0;
        if (!rst_n) begin
            evq.delete();
            m_open = 1'b1;
            m_sum  = 0;
            m_cnt  = 0;
            for (int k = 0; k < NDUT; k++) begin
                exp_d[k] = 0; exp_sof[k] = 0; exp_eof[k] = 0; exp_ovf[k] = 0;
            end
        end else if (evq.size() > 0 && evq[0].due == cyc) begin
            e   = evq.pop_front();
            hit = 1'b1;
            for (int k = 0; k < NDUT; k++) begin
                r  = e.sum >>> cfg_sh[k];
                mx = (longint'(1) <<< cfg_dos[k]) - 1;
                exp_ovf[k] = (r > mx);
                exp_d[k]   = (r > mx) ? mx : r;
                exp_sof[k] = e.sof;
                exp_eof[k] = e.eof;
            end
        end
        for (int k = 0; k < NDUT; k++) begin
            exp_en[k] = hit;
            chk("en",   k, longint'(act_en[k]),  longint'(exp_en[k]));
            chk("data", k, longint'(act_d[k]),   exp_d[k]);
            chk("sof",  k, longint'(act_sof[k]), longint'(exp_sof[k]));
            chk("eof",  k, longint'(act_eof[k]), longint'(exp_eof[k]));
            chk("ovf",  k, longint'(act_ovf[k]), longint'(exp_ovf[k]));
            if (act_en[k]) begin
                strobes[k]  = strobes[k] + 1;
                last_d[k]   = longint'(act_d[k]);
                last_sof[k] = act_sof[k];
                last_eof[k] = act_eof[k];
                last_ovf[k] = act_ovf[k];
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input bit s, input bit e, input int i, input int q);
        @(posedge clk);
        #1;
        en_i  = 1'b1;
        sof_i = s;
        eof_i = e;
        di    = 16'(i);
        dq    = 16'(q);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            en_i  = 1'b0;
            sof_i = 1'b0;
            eof_i = 1'b0;
            di    = 16'h5a5a;
            dq    = 16'ha5a5;
        end
    endtask

    task automatic clr_stats();
        for (int k = 0; k < NDUT; k++) strobes[k] = 0;
    endtask

    // Pin the observed strobe count and last strobe values against hand results
    task automatic lit(input string name, input int k, input int n,
                       input longint d, input bit s, input bit e, input bit o);
        chk({name, "_n"},   k, longint'(strobes[k]),  longint'(n));
        chk({name, "_d"},   k, last_d[k],             d);
        chk({name, "_sof"}, k, longint'(last_sof[k]), longint'(s));
        chk({name, "_eof"}, k, longint'(last_eof[k]), longint'(e));
        chk({name, "_ovf"}, k, longint'(last_ovf[k]), longint'(o));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < NDUT; k++) begin
            strobes[k] = 0; last_d[k] = 0; last_sof[k] = 0; last_eof[k] = 0; last_ovf[k] = 0;
        end
        rst_n = 1'b0;
        en_i = 1'b0; sof_i = 1'b0; eof_i = 1'b0; di = '0; dq = '0;
        idle(4);
        rst_n = 1'b1;
        idle(2);

        // 256 samples of (100,-200): 256*50000
        clr_stats();
        for (int j = 0; j < 256; j++) send(j == 0, 1'b0, 100, -200);
        idle(6);
        lit("s1", 0, 1, 64'd12800000, 1'b1, 1'b0, 1'b0);
        lit("s1", 1, 1, 64'd65535,    1'b1, 1'b0, 1'b1);
        lit("s1", 2, 1, 64'd195,      1'b1, 1'b0, 1'b0);

        // 10 samples of (3,4) with en toggling, sof first and eof last
        clr_stats();
        for (int j = 0; j < 10; j++) begin
            send(j == 0, j == 9, 3, 4);
            idle(1);
        end
        idle(6);
        lit("s2", 0, 1, 64'd250, 1'b1, 1'b1, 1'b0);

        // single full-scale sample with sof+eof; strobe visible after edge t+3
        clr_stats();
        send(1'b1, 1'b1, -32768, -32768);
        idle(3);
        chk("s3_lat", 0, longint'(strobes[0]), 64'd0);
        idle(1);
        chk("s3_lat", 0, longint'(act_en[0]), 64'd1);
        idle(4);
        lit("s3", 0, 1, 64'd2147483648, 1'b1, 1'b1, 1'b0);
        lit("s3", 1, 1, 64'd65535,      1'b1, 1'b1, 1'b1);

        // 256 samples of (1000,1000): saturation vs SHIFT=16
        clr_stats();
        for (int j = 0; j < 256; j++) send(j == 0, 1'b0, 1000, 1000);
        idle(6);
        lit("s4", 0, 1, 64'd512000000, 1'b1, 1'b0, 1'b0);
        lit("s4", 1, 1, 64'd65535,     1'b1, 1'b0, 1'b1);
        lit("s4", 2, 1, 64'd7812,      1'b1, 1'b0, 1'b0);

        // sof restart at sample 50 discards the partial block
        clr_stats();
        for (int j = 0; j < 306; j++) send(j == 0 || j == 50, 1'b0, 1, 0);
        idle(6);
        lit("s5", 0, 1, 64'd256, 1'b1, 1'b0, 1'b0);

        // reset 100 samples into a block, then 256 samples without sof
        clr_stats();
        for (int j = 0; j < 100; j++) send(j == 0, 1'b0, 2, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        en_i  = 1'b0;
        #2;
        chk("s6_rst_d",  0, longint'(act_d[0]),  64'd0);
        chk("s6_rst_en", 0, longint'(act_en[0]), 64'd0);
        idle(3);
        rst_n = 1'b1;
        for (int j = 0; j < 256; j++) send(1'b0, 1'b0, 2, 0);
        idle(6);
        lit("s6", 0, 1, 64'd1024, 1'b0, 1'b0, 1'b0);

        // eof on the 256th sample, then a back-to-back 3-sample block
        clr_stats();
        for (int j = 0; j < 256; j++) send(j == 0, j == 255, 1, 1);
        chk("s7_first", 0, longint'(strobes[0]), 64'd0);
        for (int j = 0; j < 3; j++) send(1'b0, j == 2, 1, 1);
        idle(6);
        lit("s7", 0, 2, 64'd6, 1'b0, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
